// File: rtl/sub_serial_32.sv
// Byte-serial two's complement subtractor: in1 - in2 computed one byte per cycle,
// LSB first, with signed overflow / not-equal / less-than flags at completion.

module sub_serial_32_byte (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] diff,
  output logic       cout
);
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {8'b0, cin};
endmodule

module sub_serial_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [NB-1:0][7:0]  a_q, b_q, res_q, res_nxt;
  logic [1:0]          cnt_q;
  logic                carry_q;
  logic [7:0]          diff;
  logic                cout;
  logic                last;
  logic                ovf_nxt;

  sub_serial_32_byte u_byte (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .diff (diff),
    .cout (cout)
  );

  // only the lane addressed by the counter takes the fresh byte
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign res_nxt[i] = (cnt_q == 2'(i)) ? diff : res_q[i];
  end

  assign last    = (cnt_q == 2'(NB - 1));
  assign ovf_nxt = (a_q[NB-1][7] != b_q[NB-1][7]) && (res_nxt[NB-1][7] != a_q[NB-1][7]);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = CALC;
      end
      CALC: if (last) state_d = DONE;
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      overflow   <= 1'b0;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          a_q     <= in1;
          b_q     <= in2;
          cnt_q   <= '0;
          carry_q <= 1'b1;
        end
        CALC: begin
          res_q   <= res_nxt;
          carry_q <= cout;
          cnt_q   <= cnt_q + 2'd1;
          if (last) begin
            overflow   <= ovf_nxt;
            isNotEqual <= |res_nxt;
            isLessThan <= res_nxt[NB-1][7] ^ ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
endmodule

// File: doc/sub_serial_32.md
SUB_SERIAL_32 -- requirements
Module: sub_serial_32

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, the operand width; it SHALL be fixed at 32 (four byte lanes).
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 start  input  1  request to begin a subtraction; honoured only while ready=1.
REQ-005 in1  input  32  minuend, two's complement.
REQ-006 in2  input  32  subtrahend, two's complement.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 valid  output  1  one-cycle pulse marking result and flags as freshly complete.
REQ-009 result  output  32  in1 - in2, modulo 2^32.
REQ-010 overflow  output  1  signed overflow of the subtraction.
REQ-011 isNotEqual  output  1  high when in1 != in2.
REQ-012 isLessThan  output  1  high when in1 < in2 (signed).

Function
REQ-013 Subtraction SHALL be computed as in1 + ~in2 + 1, byte-serially, one 8-bit byte per cycle, least significant byte first.
REQ-014 A registered carry SHALL link the bytes; it SHALL be set to 1 on accept and SHALL take each byte's carry-out.
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE; CALC SHALL use a 2-bit byte counter, 0..3.
REQ-016 IDLE: ready=1; start=1 at an edge SHALL latch in1/in2 into internal registers, clear the counter, set carry=1 and enter CALC.
REQ-017 CALC: each edge SHALL write byte[counter] of result and increment the counter; after byte 3 it SHALL enter DONE.
REQ-018 DONE: valid=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: start accepted at edge T0 puts valid high in the cycle after edge T4, and ready is high again after edge T5.
REQ-020 Maximum throughput SHALL be one operation per 6 cycles.
REQ-021 in1/in2 SHALL be sampled only at accept; changes during CALC/DONE SHALL NOT affect the operation in progress.
REQ-022 start while ready=0 SHALL be ignored and not queued.
REQ-023 start=1 held continuously SHALL start a new operation on each return to IDLE.
REQ-024 overflow SHALL equal (a[31] != b[31]) AND (result[31] != a[31]), using the latched operands; it SHALL be evaluated when byte 3 is written.
REQ-025 isNotEqual SHALL equal the OR of all bits of the final result.
REQ-026 isLessThan SHALL equal result[31] XOR overflow.
REQ-027 result and all flags SHALL update only on byte writes and on completion.
REQ-028 result and all flags SHALL hold stable from valid until the next accept; partial result bytes MAY be visible during CALC.

Reset
REQ-029 While reset_n=0 at an edge, the state SHALL become IDLE and ready SHALL be 1.
REQ-030 While reset_n=0 at an edge, valid, result, overflow, isNotEqual, isLessThan, the carry and the counter SHALL become 0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abort the operation with no valid pulse.
REQ-032 reset_n=0 SHALL take priority over start in the same cycle.

Verification
REQ-033 in1=0x0000_0005, in2=0x0000_0003, start at T0 -> at T4+: valid=1, result=0x0000_0002, overflow=0, isNotEqual=1, isLessThan=0; ready=1 after T5.
REQ-034 in1=0x0000_0100, in2=0x0000_0001 (borrow across byte lanes) -> result=0x0000_00FF, isLessThan=0; in1=in2=0x1234_5678 -> result=0, isNotEqual=0, isLessThan=0.
REQ-035 in1=0x8000_0000, in2=0x0000_0001 -> result=0x7FFF_FFFF, overflow=1, isLessThan=1; in1=0x7FFF_FFFF, in2=0xFFFF_FFFF -> result=0x8000_0000, overflow=1, isLessThan=0.
REQ-036 start pulsed at T2 during CALC with different operands -> ignored; first result unchanged, exactly one valid pulse.
REQ-037 reset_n=0 for one cycle at T2 of an operation -> next cycle: ready=1, all outputs 0, no valid pulse; a fresh start then completes normally.
REQ-038 start held high for 12 cycles with in1=3, in2=-2 (0xFFFF_FFFE) -> two valid pulses 6 cycles apart, each with result=0x0000_0005.
